// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a byte store in front of the serializer.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          RsTx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [15:0]   baud_cnt;
  logic [15:0]   baud_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          line_next;
  logic          bit_end;
  logic          pop;
  logic          push;
  logic [7:0]    head;
  logic [CW-1:0] count;

  assign push       = tx_valid & tx_ready;
  assign fifo_count = count;
  assign tx_busy    = (state != IDLE) || (count != {CW{1'b0}});

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign tx_ready = (count != CW'(FIFO_DEPTH));
  assign head     = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count <= count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count <= count - {{(CW-1){1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] hold;
  logic       full;

  assign tx_ready = ~full;
  assign head     = hold;
  assign count    = {{(CW-1){1'b0}}, full};

  // Single holding register; push needs it empty and pop needs it full, so they never coincide.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold <= 8'h00;
      full <= 1'b0;
    end else if (push) begin
      hold <= tx_data;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end else begin
      full <= full;
    end
  end
`endif

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Serializer datapath; the line is registered so it never glitches.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      RsTx     <= 1'b1;
    end else begin
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      RsTx     <= line_next;
    end
  end

  // Next-state logic; line_next is the level the line takes after the coming edge.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    line_next  = RsTx;
    pop        = 1'b0;
    bit_end    = (baud_cnt == BAUD_LAST);
    case (state)
      IDLE: begin
        baud_next = 16'd0;
        bit_next  = 3'd0;
        if (count != {CW{1'b0}}) begin
          pop        = 1'b1;
          state_next = START;
          shift_next = head;
          line_next  = 1'b0;
        end else begin
          line_next = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          baud_next  = 16'd0;
          bit_next   = 3'd0;
          state_next = DATA;
          line_next  = shift[0];
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next = 16'd0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            line_next  = 1'b1;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
            line_next  = shift[1];
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = 16'd0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (count != {CW{1'b0}}) begin
            pop        = 1'b1;
            state_next = START;
            shift_next = head;
            line_next  = 1'b0;
          end else begin
            state_next = IDLE;
            line_next  = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = 16'd0;
        line_next  = 1'b1;
      end
    endcase
  end

endmodule
